// File: rtl/uart_tx_fsm.sv
// UART transmit engine: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Bit timing is derived from the shared OVERSAMPLE x baud 'sampling' strobe.
module uart_tx_fsm #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sampling,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx_d,
  output logic                 o_tx_busy,
  output logic                 o_tx_complete
);

  localparam int                CNT_W       = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        DATA_LAST   = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST   = 3'(STOP_BITS - 1);
  localparam logic              ODD_SEL     = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_BIT   = 3'd1,
    DATA_BIT    = 3'd2,
    PARITY_BIT  = 3'd3,
    STOP_BIT    = 3'd4,
    TX_COMPLETE = 3'd5
  } state_t;

  // Even parity is the XOR of the word; odd parity inverts it.
  function automatic logic parity_f(input logic [DATA_BITS-1:0] data, input logic odd);
    parity_f = (^data) ^ odd;
  endfunction

  state_t               state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]     sample_cnt_r, sample_cnt_s;
  logic [2:0]           bit_cnt_r, bit_cnt_s;
  logic                 parity_r, parity_s;
  logic                 tx_d_r, tx_d_s;
  logic                 busy_r, busy_s;
  logic                 complete_r, complete_s;
  logic                 tick_end_s;

  assign tick_end_s    = sampling && (sample_cnt_r == SAMPLE_LAST);
  assign o_tx_d        = tx_d_r;
  assign o_tx_busy     = busy_r;
  assign o_tx_complete = complete_r;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= '0;
      sample_cnt_r <= '0;
      bit_cnt_r    <= 3'd0;
      parity_r     <= 1'b0;
      tx_d_r       <= 1'b1;
      busy_r       <= 1'b0;
      complete_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      sample_cnt_r <= sample_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      parity_r     <= parity_s;
      tx_d_r       <= tx_d_s;
      busy_r       <= busy_s;
      complete_r   <= complete_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    parity_s  = parity_r;

    // The counter runs only while a bit is on the line, so each frame starts from a clean phase.
    if ((state_r == IDLE) || (state_r == TX_COMPLETE)) begin
      sample_cnt_s = '0;
    end else if (tick_end_s) begin
      sample_cnt_s = '0;
    end else if (sampling) begin
      sample_cnt_s = sample_cnt_r + CNT_W'(1'b1);
    end else begin
      sample_cnt_s = sample_cnt_r;
    end

    case (state_r)
      IDLE: begin
        if (i_tx_start) begin
          shift_s   = i_tx_data;
          parity_s  = parity_f(i_tx_data, ODD_SEL);
          bit_cnt_s = 3'd0;
          state_s   = START_BIT;
        end else begin
          state_s   = IDLE;
        end
      end
      START_BIT: begin
        if (tick_end_s) begin
          state_s = DATA_BIT;
        end else begin
          state_s = START_BIT;
        end
      end
      DATA_BIT: begin
        if (tick_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_s = 3'd0;
            state_s   = (PARITY_EN != 0) ? PARITY_BIT : STOP_BIT;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = DATA_BIT;
        end
      end
      PARITY_BIT: begin
        if (tick_end_s) begin
          state_s = STOP_BIT;
        end else begin
          state_s = PARITY_BIT;
        end
      end
      STOP_BIT: begin
        // bit_cnt is reused here to count stop bits.
        if (tick_end_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            bit_cnt_s = 3'd0;
            state_s   = TX_COMPLETE;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = STOP_BIT;
        end
      end
      TX_COMPLETE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, registered alongside it
  always_comb begin
    tx_d_s     = 1'b1;
    busy_s     = 1'b0;
    complete_s = 1'b0;
    case (state_s)
      IDLE: begin
        tx_d_s = 1'b1;
      end
      START_BIT: begin
        tx_d_s = 1'b0;
        busy_s = 1'b1;
      end
      DATA_BIT: begin
        tx_d_s = shift_s[0];
        busy_s = 1'b1;
      end
      PARITY_BIT: begin
        tx_d_s = parity_s;
        busy_s = 1'b1;
      end
      STOP_BIT: begin
        tx_d_s = 1'b1;
        busy_s = 1'b1;
      end
      TX_COMPLETE: begin
        tx_d_s     = 1'b1;
        busy_s     = 1'b1;
        complete_s = 1'b1;
      end
      default: begin
        tx_d_s     = 1'b1;
        busy_s     = 1'b0;
        complete_s = 1'b0;
      end
    endcase
  end

endmodule
